lcd_16207_timed_ctrl: RTL and testbench

Avalon-MM slave that drives an HD44780-compatible 16207 character LCD. It generates the LCD bus cycle timing itself (RS/RW setup, E pulse width, hold, recovery) and stalls the master with waitrequest until each access completes. A parameter selects 8-bit or 4-bit (two-nibble) interface mode. It sits between the Nios/Avalon interconnect and the board LCD pins, and replaces the untimed pass-through LCD slave.

---
 rtl/lcd_16207_timed_ctrl.sv | 133 +++++++++++++
 tb/tb_lcd_16207_timed_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_16207_timed_ctrl.sv
// lcd_16207_timed_ctrl: Avalon-MM slave generating timed HD44780 (16207) LCD bus cycles
module lcd_16207_timed_ctrl #(
    parameter int MODE4   = 0,
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);
    localparam int T_A  = (T_SETUP > T_EPW) ? T_SETUP : T_EPW;
    localparam int T_B  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int TMAX = (T_A > T_B) ? T_A : T_B;
    localparam int CW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, GAP, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          nib;
    logic          fin;
    logic          oe;
    logic [7:0]    dout;
    logic [3:0]    wd_lo;
    logic          req;
    logic          last_nib;

    assign req         = read | write;
    assign waitrequest = req && (state != DONE);
    assign last_nib    = (MODE4 == 0) || nib;
    assign LCD_data    = oe ? dout : 8'bz;

    // Bus-cycle sequencer: phase counter restarts on every state change, LCD pins are registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            nib      <= 1'b0;
            fin      <= 1'b0;
            oe       <= 1'b0;
            dout     <= '0;
            wd_lo    <= '0;
            readdata <= '0;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_RW   <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        state  <= SETUP;
                        nib    <= 1'b0;
                        fin    <= 1'b0;
                        LCD_RS <= address[1];
                        LCD_RW <= address[0];
                        oe     <= !address[0];
                        wd_lo  <= writedata[3:0];
                        dout   <= (MODE4 != 0) ? {writedata[7:4], 4'b0} : writedata;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(T_SETUP - 1)) begin
                        state <= EHIGH;
                        cnt   <= '0;
                        LCD_E <= 1'b1;
                    end
                end
                EHIGH: begin
                    if (cnt == CW'(T_EPW - 1)) begin
                        state <= HOLD;
                        cnt   <= '0;
                        LCD_E <= 1'b0;
                        if (LCD_RW) begin
                            if (MODE4 == 0)
                                readdata <= LCD_data;
                            else if (nib)
                                readdata[3:0] <= LCD_data[7:4];
                            else
                                readdata[7:4] <= LCD_data[7:4];
                        end
                    end
                end
                HOLD: begin
                    if (cnt == CW'(T_HOLD - 1)) begin
                        cnt <= '0;
                        if (last_nib) begin
                            state <= DONE;
                            oe    <= 1'b0;
                        end else begin
                            nib   <= 1'b1;
                            dout  <= {wd_lo, 4'b0};
                            state <= (T_GAP == 0) ? SETUP : GAP;
                            oe    <= (T_GAP == 0) && !LCD_RW;
                        end
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    fin   <= 1'b1;
                    state <= (T_GAP == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (cnt == CW'(T_GAP - 1)) begin
                        cnt <= '0;
                        if (fin) begin
                            state <= IDLE;
                        end else begin
                            state <= SETUP;
                            oe    <= !LCD_RW;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_16207_timed_ctrl.sv
// tb_lcd_16207_timed_ctrl: directed vector bench for the timed LCD controller in 8-bit and 4-bit modes
module tb_lcd_16207_timed_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address;
    logic [7:0] writedata;
    logic       rd8, wr8, rd4, wr4, en8, en4;
    logic [7:0] mv8, mv4, rdata8, rdata4;
    logic       wait8, wait4, E8, E4, RS8, RS4, RW8, RW4;
    wire  [7:0] bus8, bus4;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_rd [2];

    typedef struct {
        bit         m;
        logic [1:0] a;
        bit         both;
        logic [7:0] wd;
        logic [7:0] lv;
        int         lat;
        int         ecnt;
        int         elow;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [8];

    assign bus8 = en8 ? mv8 : 8'bz;
    assign bus4 = en4 ? mv4 : 8'bz;

    always #5 clk = ~clk;

    lcd_16207_timed_ctrl #(.MODE4(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(rd8), .write(wr8),
        .writedata(writedata), .readdata(rdata8), .waitrequest(wait8),
        .LCD_E(E8), .LCD_RS(RS8), .LCD_RW(RW8), .LCD_data(bus8)
    );

    lcd_16207_timed_ctrl #(.MODE4(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(rd4), .write(wr4),
        .writedata(writedata), .readdata(rdata4), .waitrequest(wait4),
        .LCD_E(E4), .LCD_RS(RS4), .LCD_RW(RW4), .LCD_data(bus4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One Avalon access on the selected instance, with a simple LCD model answering reads while E is high
    task automatic xfer(input bit m, input logic [1:0] a, input bit both, input logic [7:0] wd,
                        input logic [7:0] lv, output int lat, output int ecnt, output int elow,
                        output logic [7:0] d1, output logic [1:0] rsrw, output logic [7:0] seen,
                        output logic [7:0] rdat, output bit bad);
        logic       e, pe, w;
        logic [7:0] b, mv;
        int         pulses, lowrun;
        lat = -1; ecnt = 0; elow = 0; d1 = '0; rsrw = '0; seen = '0; rdat = '0; bad = 0;
        pe = 1'b0; pulses = 0; lowrun = 0; mv = 8'hAA;
        address = a;
        writedata = wd;
        if (m) begin
            rd4 = a[0] | both; wr4 = ~a[0] | both; en4 = a[0]; mv4 = mv;
        end else begin
            rd8 = a[0] | both; wr8 = ~a[0] | both; en8 = a[0]; mv8 = mv;
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            e = m ? E4 : E8;
            w = m ? wait4 : wait8;
            b = m ? bus4 : bus8;
            if (c == 1) begin
                d1 = b;
                rsrw = m ? {RS4, RW4} : {RS8, RW8};
            end
            if (!e && pe) pulses++;
            if (!e && pulses == 1) lowrun++;
            if (e && !pe) begin
                if (pulses == 1) elow = lowrun;
                if (!a[0]) seen = m ? {seen[3:0], b[7:4]} : b;
            end
            if (e) ecnt++;
            if (a[0] && b !== mv) bad = 1;
            if (!a[0] && e && m && b[3:0] !== 4'h0) bad = 1;
            mv = (a[0] && e) ? (m ? ((pulses == 0) ? {lv[7:4], 4'h0} : {lv[3:0], 4'h0}) : lv) : 8'hAA;
            if (m) mv4 = mv; else mv8 = mv;
            pe = e;
            if (!w) begin
                lat = c;
                rdat = m ? rdata4 : rdata8;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (m) begin
            rd4 = 0; wr4 = 0; en4 = 1; mv4 = 8'hAA;
        end else begin
            rd8 = 0; wr8 = 0; en8 = 1; mv8 = 8'hAA;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ecnt, elow;
        logic [7:0] d1, seen, rdat, exp_d1;
        logic [1:0] rsrw;
        bit bad, e_seen, rw_low;

        vecs[0] = '{0, 2'b10, 0, 8'h41, 8'h00, 17, 12, 0,  8'h41};
        vecs[1] = '{0, 2'b01, 0, 8'h55, 8'h80, 17, 12, 0,  8'h80};
        vecs[2] = '{0, 2'b11, 1, 8'h55, 8'h3C, 17, 12, 0,  8'h3C};
        vecs[3] = '{0, 2'b00, 0, 8'h01, 8'h00, 17, 12, 0,  8'h01};
        vecs[4] = '{1, 2'b10, 0, 8'h3C, 8'h00, 43, 24, 14, 8'h3C};
        vecs[5] = '{1, 2'b01, 0, 8'h55, 8'h5A, 43, 24, 14, 8'h5A};
        vecs[6] = '{1, 2'b00, 1, 8'h28, 8'h00, 43, 24, 14, 8'h28};
        vecs[7] = '{1, 2'b11, 0, 8'h55, 8'hC3, 43, 24, 14, 8'hC3};
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        reset_n = 0; address = 2'b00; writedata = 8'h00;
        rd8 = 1; wr8 = 0; rd4 = 0; wr4 = 0;
        en8 = 1; en4 = 1; mv8 = 8'hAA; mv4 = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_E8", E8, 0);
        chk("rst_E4", E4, 0);
        chk("rst_RW8", RW8, 1);
        chk("rst_RW4", RW4, 1);
        chk("rst_RS8", RS8, 0);
        chk("rst_bus8", bus8, 8'hAA);
        chk("rst_bus4", bus4, 8'hAA);
        chk("rst_rdata8", rdata8, 8'h00);
        chk("rst_rdata4", rdata4, 8'h00);
        chk("rst_wait_req", wait8, 1);
        chk("rst_wait_idle", wait4, 0);
        rd8 = 0;
        #1;
        chk("rst_wait_drop", wait8, 0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].m, vecs[i].a, vecs[i].both, vecs[i].wd, vecs[i].lv,
                 lat, ecnt, elow, d1, rsrw, seen, rdat, bad);
            exp_d1 = vecs[i].a[0] ? 8'hAA : (vecs[i].m ? {vecs[i].wd[7:4], 4'h0} : vecs[i].wd);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_e_cycles", i), ecnt, vecs[i].ecnt);
            chk($sformatf("v%0d_e_low_between", i), elow, vecs[i].elow);
            chk($sformatf("v%0d_rs_rw", i), rsrw, vecs[i].a);
            chk($sformatf("v%0d_bus_cycle1", i), d1, exp_d1);
            chk($sformatf("v%0d_bus_integrity", i), bad, 0);
            if (vecs[i].a[0]) begin
                last_rd[vecs[i].m] = vecs[i].data;
            end else begin
                chk($sformatf("v%0d_write_data", i), seen, vecs[i].data);
            end
            chk($sformatf("v%0d_readdata", i), rdat, last_rd[vecs[i].m]);
            repeat (12) @(posedge clk);
            #1;
        end

        xfer(0, 2'b10, 0, 8'h42, 8'h00, lat, ecnt, elow, d1, rsrw, seen, rdat, bad);
        chk("b2b_first_latency", lat, 17);
        xfer(0, 2'b10, 0, 8'h43, 8'h00, lat, ecnt, elow, d1, rsrw, seen, rdat, bad);
        chk("b2b_second_latency", lat, 27);
        chk("b2b_second_data", seen, 8'h43);
        chk("b2b_readdata_kept", rdat, 8'h3C);
        repeat (12) @(posedge clk);
        #1;

        address = 2'b10; writedata = 8'h41; en8 = 0; wr8 = 1;
        repeat (6) @(negedge clk);
        chk("midrst_E_before", E8, 1);
        reset_n = 0;
        #1;
        chk("midrst_E", E8, 0);
        chk("midrst_RW", RW8, 1);
        chk("midrst_wait", wait8, 1);
        en8 = 1; mv8 = 8'hAA;
        #1;
        chk("midrst_bus_released", bus8, 8'hAA);
        chk("midrst_rdata", rdata8, 8'h00);
        wr8 = 0;
        @(negedge clk);
        reset_n = 1;
        e_seen = 0; rw_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (E8) e_seen = 1;
            if (!RW8) rw_low = 1;
        end
        chk("midrst_no_resume_E", e_seen, 0);
        chk("midrst_no_resume_RW", rw_low, 0);
        @(posedge clk);
        #1;
        xfer(0, 2'b10, 0, 8'h41, 8'h00, lat, ecnt, elow, d1, rsrw, seen, rdat, bad);
        chk("postrst_latency", lat, 17);
        chk("postrst_e_cycles", ecnt, 12);
        chk("postrst_data", seen, 8'h41);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
